// File: rtl/branch_cond_unit.sv
// branch_cond_unit: holds the architectural ALU flags {N,Z,C,V}, accepts branch
// requests over a valid/ready handshake, evaluates the 4-bit condition code and,
// for a taken branch, emits a one-cycle PC-load pulse with a registered target
// followed by a fixed-length flush of the younger pipeline stages.
//
// Optional feature macro: BRANCH_FLAG_FWD_EN
//   defined   : a flag write coinciding with an accept is bypassed into the
//               condition evaluation (no stall).
//   undefined : br_ready drops while flags_we is high, so the branch waits one
//               cycle and evaluates on the updated flags register.
module branch_cond_unit #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        flags_in,
    input  logic              flags_we,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic [3:0]        flags_q,
    output logic              resolved,
    output logic              taken,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    // Condition-code evaluation against flags {N,Z,C,V}; codes 1011..1111 never take.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = 1'b1;          // AL
            4'b0001: r = z;             // EQ
            4'b0010: r = ~z;            // NE
            4'b0011: r = n;             // LT
            4'b0100: r = ~n;            // GE
            4'b0101: r = ~n & ~z;       // GT
            4'b0110: r = n | z;         // LE
            4'b0111: r = c;             // CS
            4'b1000: r = ~c;            // CC
            4'b1001: r = v;             // VS
            4'b1010: r = ~v;            // VC
            default: r = 1'b0;          // NV
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          flags_d;
    logic                resolved_d, taken_d, pc_load_d, flush_d;
    logic [ADDR_W-1:0]   pc_target_d;
    logic [3:0]          eval_flags_s;
    logic                accept_s;
    logic                cond_ok_s;

    // Handshake ready: only in IDLE, never during reset, stalled by a flag write when not bypassing.
    always_comb begin
        br_ready = 1'b0;
        if (rst) begin
            br_ready = 1'b0;
        end else if (state_q == IDLE) begin
`ifdef BRANCH_FLAG_FWD_EN
            br_ready = 1'b1;
`else
            br_ready = ~flags_we;
`endif
        end else begin
            br_ready = 1'b0;
        end
    end

    // Select the flags the condition is evaluated on and decide the outcome.
    always_comb begin
`ifdef BRANCH_FLAG_FWD_EN
        eval_flags_s = flags_we ? flags_in : flags_q;
`else
        eval_flags_s = flags_q;
`endif
        accept_s  = br_valid & br_ready;
        cond_ok_s = cond_eval(br_cond, eval_flags_s);
    end

    // Next-state and registered-output logic for the IDLE/FLUSH controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        resolved_d  = 1'b0;
        taken_d     = 1'b0;
        pc_load_d   = 1'b0;
        flush_d     = 1'b0;
        pc_target_d = pc_target;
        case (state_q)
            IDLE: begin
                if (flags_we) begin
                    flags_d = flags_in;
                end else begin
                    flags_d = flags_q;
                end
                if (accept_s) begin
                    resolved_d = 1'b1;
                    taken_d    = cond_ok_s;
                    if (cond_ok_s) begin
                        pc_load_d   = 1'b1;
                        pc_target_d = br_target;
                        cnt_d       = FLUSH_INIT;
                        flush_d     = 1'b1;
                        state_d     = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // Flag writer is squashed here, so flags_we is ignored.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, flags and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            flags_q   <= 4'd0;
            resolved  <= 1'b0;
            taken     <= 1'b0;
            pc_load   <= 1'b0;
            flush     <= 1'b0;
            pc_target <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            resolved  <= resolved_d;
            taken     <= taken_d;
            pc_load   <= pc_load_d;
            flush     <= flush_d;
            pc_target <= pc_target_d;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: the stimulus side pushes the expected
// resolution (outcome, target, cycle) when a request is accepted; an independent
// monitor pops and compares whenever the DUT presents resolved/pc_load.
module tb_branch_cond_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    flags_in;
    logic          flags_we;
    logic          br_valid;
    logic [3:0]    br_cond;
    logic [AW-1:0] br_target;
    logic          br_ready;
    logic [3:0]    flags_q;
    logic          resolved;
    logic          taken;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          flush;

    branch_cond_unit #(.ADDR_W(AW), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .flags_in(flags_in), .flags_we(flags_we),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .br_ready(br_ready), .flags_q(flags_q), .resolved(resolved),
        .taken(taken), .pc_load(pc_load), .pc_target(pc_target), .flush(flush)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          tk;
        logic [31:0] tgt;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_tgt = 32'd0;

    typedef struct packed {
        logic [3:0] f;
        logic [3:0] c;
        logic       t;
    } vec_t;

    localparam vec_t VEC [18] = '{
        '{4'b0000, 4'b0010, 1'b1},   // NE, Z=0
        '{4'b0000, 4'b0110, 1'b0},   // LE
        '{4'b0000, 4'b0101, 1'b1},   // GT
        '{4'b0000, 4'b0000, 1'b1},   // AL
        '{4'b0000, 4'b1000, 1'b1},   // CC
        '{4'b0000, 4'b1010, 1'b1},   // VC
        '{4'b0010, 4'b0111, 1'b1},   // CS
        '{4'b0010, 4'b1000, 1'b0},   // CC
        '{4'b0001, 4'b1001, 1'b1},   // VS
        '{4'b0001, 4'b1010, 1'b0},   // VC
        '{4'b1100, 4'b0110, 1'b1},   // LE
        '{4'b1100, 4'b0100, 1'b0},   // GE
        '{4'b1100, 4'b1111, 1'b0},   // NV
        '{4'b1000, 4'b0011, 1'b1},   // LT
        '{4'b0100, 4'b0101, 1'b0},   // GT with Z
        '{4'b0100, 4'b0001, 1'b1},   // EQ
        '{4'b0000, 4'b0001, 1'b0},   // EQ, Z=0
        '{4'b0000, 4'b0011, 1'b0}    // LT, N=0
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every resolution must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (resolved || pc_load)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resolve: resolved=%0b pc_load=%0b with empty scoreboard", resolved, pc_load);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resolved", {31'd0, resolved}, 32'd1);
                chk("resolve_cycle", cyc, mon_e.cyc);
                chk("taken", {31'd0, taken}, {31'd0, mon_e.tk});
                chk("pc_load", {31'd0, pc_load}, {31'd0, mon_e.tk});
                if (mon_e.tk) last_tgt = mon_e.tgt;
                chk("pc_target", pc_target, last_tgt);
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] t, input bit exp_tk,
                         input logic we, input logic [3:0] fl, output int acc);
        br_valid  = 1'b1;
        br_cond   = c;
        br_target = t;
        flags_we  = we;
        flags_in  = fl;
        acc = -1;
        for (int k = 0; k < 40 && acc < 0; k++) begin
            @(negedge clk);
            if (br_ready) begin
                acc = cyc + 1;
                exp_q.push_back('{exp_tk, t, acc});
            end
            @(posedge clk);
            #1;
            flags_we = 1'b0;
        end
        br_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: cond=%b never accepted", c);
        end
    endtask

    task automatic wr_flags(input logic [3:0] f);
        flags_we = 1'b1;
        flags_in = f;
        @(posedge clk);
        #1;
        flags_we = 1'b0;
        chk("flags_write", {28'd0, flags_q}, {28'd0, f});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int c0;
        rst       = 1'b1;
        flags_in  = 4'd0;
        flags_we  = 1'b0;
        br_valid  = 1'b0;
        br_cond   = 4'd0;
        br_target = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, br_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {28'd0, flags_q}, 32'd0);
        chk("rst_outputs", {28'd0, resolved, taken, pc_load, flush}, 32'd0);
        chk("rst_pc_target", pc_target, 32'd0);
        chk("idle_ready", {31'd0, br_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Flag write then EQ branch, check flush window and ready
        wr_flags(4'b0100);
        issue(4'b0001, 32'h100, 1'b1, 1'b0, 4'd0, acc);
        chk("flush_c1", {30'd0, flush, br_ready}, 32'b10);
        @(posedge clk);
        #1;
        chk("flush_c2", {30'd0, flush, br_ready}, 32'b10);
        @(posedge clk);
        #1;
        chk("flush_end", {30'd0, flush, br_ready}, 32'b01);

        // Back-to-back not-taken stream
        wr_flags(4'b1000);
        c0 = cyc;
        issue(4'b0100, 32'h111, 1'b0, 1'b0, 4'd0, acc);
        issue(4'b0101, 32'h222, 1'b0, 1'b0, 4'd0, acc);
        issue(4'b1011, 32'h333, 1'b0, 1'b0, 4'd0, acc);
        chk("b2b_accepts", acc - c0, 32'd3);

        // Condition-code table
        for (int i = 0; i < 18; i++) begin
            wr_flags(VEC[i].f);
            issue(VEC[i].c, 32'h1000 + 32'(i) * 32'd16, VEC[i].t, 1'b0, 4'd0, acc);
            repeat (3) @(posedge clk);
            #1;
        end

        // Flag write coinciding with a CS branch
        wr_flags(4'b0000);
        c0 = cyc;
        issue(4'b0111, 32'h200, 1'b1, 1'b1, 4'b0010, acc);
`ifdef BRANCH_FLAG_FWD_EN
        chk("coincide_latency", acc - c0, 32'd1);
`else
        chk("coincide_latency", acc - c0, 32'd2);
`endif
        chk("coincide_flags", {28'd0, flags_q}, 32'b0010);

        // Flag write and request during FLUSH: both held off
        c0 = cyc;
        issue(4'b0001, 32'h300, 1'b0, 1'b1, 4'b1111, acc);
        chk("flush_hold_accept", acc - c0, 32'd3);
        chk("flush_flags_kept", {28'd0, flags_q}, 32'b0010);

        // Reset in the first flush cycle
        @(posedge clk);
        #1;
        issue(4'b0000, 32'h500, 1'b1, 1'b0, 4'd0, acc);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {28'd0, resolved, taken, pc_load, flush}, 32'd0);
        chk("async_rst_target", pc_target, 32'd0);
        chk("async_rst_ready", {31'd0, br_ready}, 32'd0);
        last_tgt = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_flags", {28'd0, flags_q}, 32'd0);
        issue(4'b0000, 32'h40, 1'b1, 1'b0, 4'd0, acc);
        repeat (4) @(posedge clk);
        #1;
        chk("final_pc_target", pc_target, 32'h40);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Execute-stage consumer of the ALU status flags `{neg, zero, carry, overflow}`. It holds the architectural flags register and accepts branch requests through a valid/ready handshake. Each request's 4-bit condition is evaluated against the flags. A taken branch produces a one-cycle PC-load pulse plus a fixed-length pipeline flush. It sits between the ALU flag output and the fetch-stage PC mux.

## Interface
- `ADDR_W`, 32: width of branch target / PC.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a taken branch; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flags_in` in 4: ALU flags `{neg, zero, carry, overflow}`.
- `flags_we` in 1: write `flags_in` into the flags register.
- `br_valid` in 1: branch request present.
- `br_cond` in 4: condition code.
- `br_target` in ADDR_W: branch destination.
- `br_ready` out 1: request can be accepted this cycle.
- `flags_q` out 4: current flags register.
- `resolved` out 1: one-cycle pulse, a branch was evaluated.
- `taken` out 1: outcome, valid only when `resolved` = 1.
- `pc_load` out 1: one-cycle pulse, load `pc_target` into the PC.
- `pc_target` out ADDR_W: registered target.
- `flush` out 1: squash younger pipeline stages.

## Operation
- Flags register:
  - Loads `flags_in` on `flags_we` while in IDLE.
  - `flags_we` is ignored in FLUSH, because the writer is squashed.
- Condition codes, with N/Z/C/V = flags:
  - 0000 AL (always), 0001 EQ (Z), 0010 NE (!Z), 0011 LT (N), 0100 GE (!N).
  - 0101 GT (!N & !Z), 0110 LE (N | Z).
  - 0111 CS (C), 1000 CC (!C), 1001 VS (V), 1010 VC (!V).
  - 1011–1111 NV: never taken, still resolved.
- FSM states are IDLE and FLUSH.
- IDLE:
  - `br_ready` = 1, except during the hazard stall (see Configuration).
  - Accept occurs on `br_valid & br_ready`.
  - Not taken: stay in IDLE.
  - Taken: register `br_target`, load the flush counter with `FLUSH_CYCLES`, go to FLUSH.
- FLUSH:
  - `br_ready` = 0 and `flush` = 1.
  - The counter decrements each cycle; on reaching 0 the FSM returns to IDLE.
  - `br_valid` is ignored; the requester holds the request until it is accepted.
- `br_cond`/`br_target` are sampled only on the accept edge.
- Outputs `resolved`, `taken`, `pc_load`, `pc_target`, `flush` are all registered.

## Timing
- Reset values:
  - `flags_q` = 0, state = IDLE, counter = 0.
  - `resolved` = `taken` = `pc_load` = `flush` = 0, `pc_target` = 0.
  - `br_ready` = 0 while `rst` is high.
- Assertion of `rst` mid-FLUSH clears state and outputs immediately (asynchronous). After deassertion the block is in IDLE.
- Accept at edge T, taken:
  - Cycle T+1: `resolved` = `taken` = `pc_load` = 1.
  - `flush` = 1 for cycles T+1 .. T+FLUSH_CYCLES.
  - `br_ready` = 1 again at T+FLUSH_CYCLES+1.
- Accept at edge T, not taken:
  - Cycle T+1: `resolved` = 1, `taken` = 0.
  - `br_ready` stays 1, so back-to-back branches are accepted on every cycle.
- `pc_target` holds its value until the next taken branch.
- `flags_we` without a branch: `flags_q` updates at the next edge.

## Configuration
- `BRANCH_FLAG_FWD_EN` defined:
  - If `flags_we` and an accept happen in the same cycle, the condition is evaluated on `flags_in` (bypass).
  - `flags_q` is also updated at that edge.
  - There is no stall.
- `BRANCH_FLAG_FWD_EN` undefined:
  - In IDLE, `br_ready` = `!flags_we`.
  - A branch that coincides with a flag write waits one cycle, then evaluates on the updated `flags_q`.
  - Resolution is therefore one cycle later than with the macro defined.

## Test plan
- Reset then idle → `flags_q` = 0, all outputs 0.
- Flag write, then branch:
  - `flags_we` = 1 with `flags_in` = 4'b0100, then `br_cond` = EQ, target 0x100.
  - → At T+1: `pc_load` = 1, `pc_target` = 0x100, `taken` = 1.
  - → `flush` high for 2 cycles; `br_ready` low for 2 cycles.
- Not-taken stream: `flags_q` = 4'b1000, three consecutive NE-false branches (GE, GT, NV) → three `resolved` pulses, `taken` = 0, `br_ready` constantly 1.
- Flag write coinciding with a branch: `flags_we` = 1 with `flags_in` = 4'b0010 in the same cycle as `br_cond` = CS.
  - → With `BRANCH_FLAG_FWD_EN`: taken at T+1.
  - → Without: `br_ready` = 0 at T, taken at T+2.
- During FLUSH, `flags_we` = 1 with `flags_in` = 4'b1111 and `br_valid` = 1 → `flags_q` unchanged, request accepted only after `br_ready` returns.
- `rst` asserted at the first flush cycle → `flush`/`pc_load` drop immediately; after release, a new AL branch to 0x40 is accepted and taken.
